// File: rtl/rv32i_pkg.sv
// RV32I execute-stage shared definitions: opcodes, fixed instruction words,
// ALU operation encoding and the EX halt-state encoding.
// Optional RV32M multiply support is selected by the RV32M_MUL_EN macro.
package rv32i_pkg;

    // Major opcodes (iw[6:0])
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    // funct7 groups
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Canonical instruction words
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [3:0] {
        ALU_ZERO,
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU
    } alu_op_e;

    typedef enum logic {
        S_RUN,
        S_HALT
    } ex_state_e;

endpackage

// File: rtl/ex_alu.sv
// Combinational decode and result computation for the EX stage.
// RV32M_MUL_EN enables MUL/MULH/MULHSU/MULHU; divide/remainder stay unrecognised.
module ex_alu
    import rv32i_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] iw_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] result_o,
    output logic        valid_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;

    assign opcode = iw_i[6:0];
    assign funct3 = iw_i[14:12];
    assign funct7 = iw_i[31:25];
    assign imm_i  = {{20{iw_i[31]}}, iw_i[31:20]};
    assign imm_s  = {{20{iw_i[31]}}, iw_i[31:25], iw_i[11:7]};
    assign imm_u  = {iw_i[31:12], 12'b0};

    // Decode: pick operation and operands; unrecognised encodings force ALU_ZERO
    always_comb begin
        op      = ALU_ZERO;
        a       = rs1_i;
        b       = rs2_i;
        valid_o = 1'b1;
        case (opcode)
            LUI:    begin op = ALU_ADD; a = '0;   b = imm_u;  end
            AUIPC:  begin op = ALU_ADD; a = pc_i; b = imm_u;  end
            JAL,
            JALR:   begin op = ALU_ADD; a = pc_i; b = 32'd4;  end
            LOAD:   begin op = ALU_ADD; b = imm_i;            end
            STORE:  begin op = ALU_ADD; b = imm_s;            end
            BRANCH,
            SYSTEM: op = ALU_ZERO;
            OP_IMM: begin
                // Immediate shifts take their amount from imm_i[4:0] = iw[24:20]
                b = imm_i;
                case (funct3)
                    3'b000:  op = ALU_ADD;
                    3'b010:  op = ALU_SLT;
                    3'b011:  op = ALU_SLTU;
                    3'b100:  op = ALU_XOR;
                    3'b110:  op = ALU_OR;
                    3'b111:  op = ALU_AND;
                    3'b001:  if (funct7 == F7_BASE) op = ALU_SLL; else valid_o = 1'b0;
                    3'b101: begin
                        if (funct7 == F7_BASE)     op = ALU_SRL;
                        else if (funct7 == F7_ALT) op = ALU_SRA;
                        else                       valid_o = 1'b0;
                    end
                    default: valid_o = 1'b0;
                endcase
            end
            OP: begin
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            3'b000:  op = ALU_ADD;
                            3'b001:  op = ALU_SLL;
                            3'b010:  op = ALU_SLT;
                            3'b011:  op = ALU_SLTU;
                            3'b100:  op = ALU_XOR;
                            3'b101:  op = ALU_SRL;
                            3'b110:  op = ALU_OR;
                            default: op = ALU_AND;
                        endcase
                    end
                    F7_ALT: begin
                        case (funct3)
                            3'b000:  op = ALU_SUB;
                            3'b101:  op = ALU_SRA;
                            default: valid_o = 1'b0;
                        endcase
                    end
`ifdef RV32M_MUL_EN
                    F7_MULDIV: begin
                        case (funct3)
                            3'b000:  op = ALU_MUL;
                            3'b001:  op = ALU_MULH;
                            3'b010:  op = ALU_MULHSU;
                            3'b011:  op = ALU_MULHU;
                            default: valid_o = 1'b0;
                        endcase
                    end
`endif
                    default: valid_o = 1'b0;
                endcase
            end
            default: valid_o = 1'b0;
        endcase
        if (!valid_o) op = ALU_ZERO;
    end

    // Execute: compute the selected operation, modulo 2^32
    always_comb begin
        result_o = '0;
        case (op)
            ALU_ADD:    result_o = a + b;
            ALU_SUB:    result_o = a - b;
            ALU_SLL:    result_o = a << b[4:0];
            ALU_SLT:    result_o = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:   result_o = {31'b0, a < b};
            ALU_XOR:    result_o = a ^ b;
            ALU_SRL:    result_o = a >> b[4:0];
            ALU_SRA:    result_o = $signed(a) >>> b[4:0];
            ALU_OR:     result_o = a | b;
            ALU_AND:    result_o = a & b;
`ifdef RV32M_MUL_EN
            ALU_MUL:    result_o = a * b;
            ALU_MULH:   result_o = 32'(($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b})) >> 32);
            ALU_MULHSU: result_o = 32'(($signed({{32{a[31]}}, a}) * $signed({32'b0, b})) >> 32);
            ALU_MULHU:  result_o = 32'(({32'b0, a} * {32'b0, b}) >> 32);
`endif
            default:    result_o = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: EX/MEM pipeline register, halt FSM, instruction
// counter and EX->ID forwarding. RV32M_MUL_EN (see ex_alu) adds multiply.
module ex_stage
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] iw_in,
    input  logic [4:0]  wb_reg_in,
    input  logic        wb_enable_in,
    input  logic        mem_we_in,
    input  logic [31:0] rs1_data_in,
    input  logic [31:0] rs2_data_in,
    input  logic        ebreak_in,
    output logic [31:0] pc_out,
    output logic [31:0] iw_out,
    output logic [4:0]  wb_reg_out,
    output logic        wb_enable_out,
    output logic        mem_we_out,
    output logic [31:0] alu_out,
    output logic [31:0] rs2_data_out,
    output logic        ebreak_out,
    output logic        df_ex_enable,
    output logic [4:0]  df_ex_reg,
    output logic [31:0] df_ex_data,
    output logic [31:0] ex_count
);

    ex_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] iw_q, iw_d;
    logic [4:0]  wb_reg_q, wb_reg_d;
    logic        wb_en_q, wb_en_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] rs2_q, rs2_d;
    logic        ebreak_q, ebreak_d;
    logic [31:0] ex_count_q, ex_count_d;

    logic [31:0] alu_result;
    logic        alu_valid;
    logic        halted;

    ex_alu u_alu (
        .pc_i     (pc_in),
        .iw_i     (iw_in),
        .rs1_i    (rs1_data_in),
        .rs2_i    (rs2_data_in),
        .result_o (alu_result),
        .valid_o  (alu_valid)
    );

    assign halted = (state_q == S_HALT);

    // Forwarding for the instruction currently in EX; loads resolve later in MEM
    assign df_ex_enable = wb_enable_in && (wb_reg_in != 5'd0) && (iw_in[6:0] != LOAD) && !halted;
    assign df_ex_reg    = wb_reg_in;
    assign df_ex_data   = alu_result;

    // Next-state: in HALT inject a NOP and freeze pc/counter, otherwise pass the EX result on
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        iw_d       = NOP;
        wb_reg_d   = '0;
        wb_en_d    = 1'b0;
        mem_we_d   = 1'b0;
        alu_d      = '0;
        rs2_d      = '0;
        ebreak_d   = 1'b1;
        ex_count_d = ex_count_q;
        if (!halted) begin
            pc_d       = pc_in;
            iw_d       = iw_in;
            wb_reg_d   = wb_reg_in;
            wb_en_d    = wb_enable_in && alu_valid && !ebreak_in;
            mem_we_d   = mem_we_in && alu_valid && !ebreak_in;
            alu_d      = alu_result;
            rs2_d      = rs2_data_in;
            ebreak_d   = ebreak_in;
            ex_count_d = (iw_in != NOP) ? ex_count_q + 32'd1 : ex_count_q;
            state_d    = ebreak_in ? S_HALT : S_RUN;
        end
    end

    // Pipeline register and halt FSM; reset overrides every other update
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RUN;
            pc_q       <= '0;
            iw_q       <= NOP;
            wb_reg_q   <= '0;
            wb_en_q    <= 1'b0;
            mem_we_q   <= 1'b0;
            alu_q      <= '0;
            rs2_q      <= '0;
            ebreak_q   <= 1'b0;
            ex_count_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            iw_q       <= iw_d;
            wb_reg_q   <= wb_reg_d;
            wb_en_q    <= wb_en_d;
            mem_we_q   <= mem_we_d;
            alu_q      <= alu_d;
            rs2_q      <= rs2_d;
            ebreak_q   <= ebreak_d;
            ex_count_q <= ex_count_d;
        end
    end

    assign pc_out        = pc_q;
    assign iw_out        = iw_q;
    assign wb_reg_out    = wb_reg_q;
    assign wb_enable_out = wb_en_q;
    assign mem_we_out    = mem_we_q;
    assign alu_out       = alu_q;
    assign rs2_data_out  = rs2_q;
    assign ebreak_out    = ebreak_q;
    assign ex_count      = ex_count_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed table-driven bench for ex_stage plus hand-written halt/reset/wrap sequences.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in, iw_in, rs1_data_in, rs2_data_in;
    logic [4:0]  wb_reg_in;
    logic        wb_enable_in, mem_we_in, ebreak_in;
    logic [31:0] pc_out, iw_out, alu_out, rs2_data_out, df_ex_data, ex_count;
    logic [4:0]  wb_reg_out, df_ex_reg;
    logic        wb_enable_out, mem_we_out, ebreak_out, df_ex_enable;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [31:0] exp_cnt;

    ex_stage dut (
        .clk           (clk),
        .reset         (reset),
        .pc_in         (pc_in),
        .iw_in         (iw_in),
        .wb_reg_in     (wb_reg_in),
        .wb_enable_in  (wb_enable_in),
        .mem_we_in     (mem_we_in),
        .rs1_data_in   (rs1_data_in),
        .rs2_data_in   (rs2_data_in),
        .ebreak_in     (ebreak_in),
        .pc_out        (pc_out),
        .iw_out        (iw_out),
        .wb_reg_out    (wb_reg_out),
        .wb_enable_out (wb_enable_out),
        .mem_we_out    (mem_we_out),
        .alu_out       (alu_out),
        .rs2_data_out  (rs2_data_out),
        .ebreak_out    (ebreak_out),
        .df_ex_enable  (df_ex_enable),
        .df_ex_reg     (df_ex_reg),
        .df_ex_data    (df_ex_data),
        .ex_count      (ex_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] iw;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        wben;
        logic        mwe;
        logic [31:0] exp_alu;
        logic        exp_wb;
        logic        exp_mwe;
        logic        exp_df;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic [31:0] pc, input logic [31:0] iw,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] rd,
                       input logic wben, input logic mwe, input logic [31:0] ealu,
                       input logic ewb, input logic emwe, input logic edf);
        vec_t v;
        v.name = n; v.pc = pc; v.iw = iw; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.wben = wben; v.mwe = mwe; v.exp_alu = ealu; v.exp_wb = ewb;
        v.exp_mwe = emwe; v.exp_df = edf;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] iw, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic wben,
                         input logic mwe, input logic ebrk);
        pc_in = pc; iw_in = iw; rs1_data_in = rs1; rs2_data_in = rs2;
        wb_reg_in = rd; wb_enable_in = wben; mem_we_in = mwe; ebreak_in = ebrk;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drive(32'h0, 32'h0000_0013, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_iw", iw_out, 32'h0000_0013);
        chk("rst_wbreg", {27'b0, wb_reg_out}, 32'h0);
        chk("rst_wben", {31'b0, wb_enable_out}, 32'h0);
        chk("rst_mwe", {31'b0, mem_we_out}, 32'h0);
        chk("rst_alu", alu_out, 32'h0);
        chk("rst_rs2", rs2_data_out, 32'h0);
        chk("rst_ebrk", {31'b0, ebreak_out}, 32'h0);
        chk("rst_cnt", ex_count, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        //  name        pc           iw            rs1           rs2           rd  wben mwe  exp_alu      wb   mwe  df
        add("addi_m1",  32'h0000_0000, 32'hFFF0_0293, 32'h0000_0000, 32'h0,         5, 1, 0, 32'hFFFF_FFFF, 1, 0, 1);
        add("sltiu",    32'h0000_0004, 32'h0012_B313, 32'hFFFF_FFFF, 32'h0,         6, 1, 0, 32'h0000_0000, 1, 0, 1);
        add("sra",      32'h0000_0008, 32'h4020_D3B3, 32'h8000_0000, 32'h0000_0021, 7, 1, 0, 32'hC000_0000, 1, 0, 1);
        add("srl",      32'h0000_000C, 32'h0020_D3B3, 32'h8000_0000, 32'h0000_0021, 7, 1, 0, 32'h4000_0000, 1, 0, 1);
        add("lw",       32'h0000_0010, 32'h7FC0_A403, 32'h0000_1000, 32'h0,         8, 1, 0, 32'h0000_17FC, 1, 0, 0);
        add("sw",       32'h0000_0014, 32'hFE20_AE23, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, 1, 32'h0000_0FFC, 0, 1, 0);
        add("addi_x0",  32'h0000_0018, 32'h0050_0013, 32'h0000_0000, 32'h0,         0, 1, 0, 32'h0000_0005, 1, 0, 0);
        add("sub",      32'h0000_001C, 32'h4020_81B3, 32'h0000_0005, 32'h0000_0007, 3, 1, 0, 32'hFFFF_FFFE, 1, 0, 1);
        add("slt",      32'h0000_0020, 32'h0020_A1B3, 32'hFFFF_FFFF, 32'h0000_0001, 3, 1, 0, 32'h0000_0001, 1, 0, 1);
        add("lui",      32'h0000_0024, 32'h1234_5237, 32'h5555_5555, 32'h0,         4, 1, 0, 32'h1234_5000, 1, 0, 1);
        add("auipc",    32'h0000_0100, 32'h0000_1217, 32'h0,         32'h0,         4, 1, 0, 32'h0000_1100, 1, 0, 1);
        add("jal",      32'h0000_0200, 32'h0080_00EF, 32'h0,         32'h0,         1, 1, 0, 32'h0000_0204, 1, 0, 1);
        add("bad_f7",   32'h0000_0204, 32'h4020_91B3, 32'h1234_5678, 32'h0000_0003, 3, 1, 0, 32'h0000_0000, 0, 0, 1);
        add("bad_opc",  32'h0000_0208, 32'h0000_007F, 32'h1234_5678, 32'h0,         0, 0, 1, 32'h0000_0000, 0, 0, 0);
        add("xori",     32'h0000_020C, 32'h0FF0_C093, 32'h0000_00F0, 32'h0,         1, 1, 0, 32'h0000_000F, 1, 0, 1);
        add("slli",     32'h0000_0210, 32'h0040_9093, 32'h0000_0001, 32'h0,         1, 1, 0, 32'h0000_0010, 1, 0, 1);
        add("srai",     32'h0000_0214, 32'h4040_D093, 32'h8000_0000, 32'h0,         1, 1, 0, 32'hF800_0000, 1, 0, 1);
`ifdef RV32M_MUL_EN
        add("mulhu",    32'h0000_0218, 32'h0220_B1B3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1, 0, 32'hFFFF_FFFE, 1, 0, 1);
`else
        add("mulhu",    32'h0000_0218, 32'h0220_B1B3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1, 0, 32'h0000_0000, 0, 0, 1);
`endif
        add("beq",      32'h0000_021C, 32'h0020_8463, 32'h0000_0001, 32'h0000_0001, 0, 0, 0, 32'h0000_0000, 0, 0, 0);
        add("nop",      32'h0000_0220, 32'h0000_0013, 32'h0,         32'h0,         0, 0, 0, 32'h0000_0000, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].pc, vecs[i].iw, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                  vecs[i].wben, vecs[i].mwe, 1'b0);
            #1;
            chk({vecs[i].name, "_dfen"}, {31'b0, df_ex_enable}, {31'b0, vecs[i].exp_df});
            if (vecs[i].exp_df) begin
                chk({vecs[i].name, "_dfreg"}, {27'b0, df_ex_reg}, {27'b0, vecs[i].rd});
                chk({vecs[i].name, "_dfdata"}, df_ex_data, vecs[i].exp_alu);
            end
            if (vecs[i].iw != 32'h0000_0013) exp_cnt = exp_cnt + 32'd1;
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_alu"}, alu_out, vecs[i].exp_alu);
            chk({vecs[i].name, "_wben"}, {31'b0, wb_enable_out}, {31'b0, vecs[i].exp_wb});
            chk({vecs[i].name, "_mwe"}, {31'b0, mem_we_out}, {31'b0, vecs[i].exp_mwe});
            chk({vecs[i].name, "_iw"}, iw_out, vecs[i].iw);
            chk({vecs[i].name, "_pc"}, pc_out, vecs[i].pc);
            chk({vecs[i].name, "_rs2"}, rs2_data_out, vecs[i].rs2);
            chk({vecs[i].name, "_cnt"}, ex_count, exp_cnt);
        end

        // Counter wrap: preload all-ones, one non-NOP must wrap to zero
        @(negedge clk);
        force dut.ex_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.ex_count_q;
        drive(32'h0000_0300, 32'h0050_0093, '0, '0, 5'd1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("wrap_pre", ex_count, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        chk("wrap_cnt", ex_count, 32'h0);
        exp_cnt = '0;

        // EBREAK passes to MEM flagged, with writeback and store suppressed
        @(negedge clk);
        drive(32'h0000_0400, 32'h0010_0073, '0, '0, 5'd0, 1'b1, 1'b1, 1'b1);
        exp_cnt = exp_cnt + 32'd1;
        @(posedge clk);
        #1;
        chk("ebrk_out", {31'b0, ebreak_out}, 32'h1);
        chk("ebrk_wben", {31'b0, wb_enable_out}, 32'h0);
        chk("ebrk_mwe", {31'b0, mem_we_out}, 32'h0);
        chk("ebrk_iw", iw_out, 32'h0010_0073);
        chk("ebrk_cnt", ex_count, exp_cnt);

        // In HALT: following ADDI is swallowed, NOP emitted, pc/counter frozen
        @(negedge clk);
        drive(32'h0000_0404, 32'h0050_0093, '0, 32'h0000_1111, 5'd1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("halt_dfen", {31'b0, df_ex_enable}, 32'h0);
        @(posedge clk);
        #1;
        chk("halt_iw", iw_out, 32'h0000_0013);
        chk("halt_cnt", ex_count, exp_cnt);
        chk("halt_wben", {31'b0, wb_enable_out}, 32'h0);
        chk("halt_alu", alu_out, 32'h0);
        chk("halt_ebrk", {31'b0, ebreak_out}, 32'h1);
        chk("halt_pc", pc_out, 32'h0000_0400);

        // Reset while halted, with a live non-NOP on the inputs: reset wins
        @(negedge clk);
        reset = 1'b1;
        drive(32'h0000_0500, 32'h0050_0093, '0, '0, 5'd1, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("rst2_cnt", ex_count, 32'h0);
        chk("rst2_iw", iw_out, 32'h0000_0013);
        chk("rst2_ebrk", {31'b0, ebreak_out}, 32'h0);
        chk("rst2_pc", pc_out, 32'h0);
        chk("rst2_mwe", {31'b0, mem_we_out}, 32'h0);

        // Back in RUN after reset
        @(negedge clk);
        reset = 1'b0;
        drive(32'h0000_0600, 32'h0050_0093, '0, '0, 5'd1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("run_dfen", {31'b0, df_ex_enable}, 32'h1);
        @(posedge clk);
        #1;
        chk("run_alu", alu_out, 32'h5);
        chk("run_wben", {31'b0, wb_enable_out}, 32'h1);
        chk("run_cnt", ex_count, 32'h1);
        chk("run_ebrk", {31'b0, ebreak_out}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have a single clock `clk`; reset is synchronous and active-high on port `reset`.
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 pc_in  in  32  PC of the instruction in EX, from ID.
REQ-005 iw_in  in  32  instruction word in EX; 32'h00000013 = NOP.
REQ-006 wb_reg_in  in  5  destination register from ID.
REQ-007 wb_enable_in  in  1  writeback request from ID.
REQ-008 mem_we_in  in  1  store flag from ID.
REQ-009 rs1_data_in, rs2_data_in  in  32 each  forwarded operands from ID.
REQ-010 ebreak_in  in  1  EBREAK flag from ID.
REQ-011 pc_out, iw_out  out  32 each  registered copies to MEM.
REQ-012 wb_reg_out  out  5; wb_enable_out  out  1; mem_we_out  out  1  registered control to MEM.
REQ-013 alu_out  out  32  registered result or effective address.
REQ-014 rs2_data_out  out  32  registered store data.
REQ-015 ebreak_out  out  1  registered halt indication.
REQ-016 df_ex_enable  out  1; df_ex_reg  out  5; df_ex_data  out  32  combinational forwarding to ID for the instruction currently in EX.
REQ-017 ex_count  out  32  number of non-NOP instructions executed.

Function
REQ-018 Latency SHALL be one cycle: inputs sampled at edge N appear on the *_out ports after edge N.
REQ-019 Immediates: I = sext(iw[31:20]); S = sext({iw[31:25],iw[11:7]}); U = {iw[31:12],12'b0}.
REQ-020 Results by opcode: LUI -> U; AUIPC -> pc+U; JAL/JALR -> pc+4; LOAD -> rs1+I; STORE -> rs1+S; BRANCH and SYSTEM -> 0.
REQ-021 OP-IMM SHALL implement ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI; iw[30] selects SRAI; shift amount = iw[24:20].
REQ-022 OP SHALL implement ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; iw[30] selects SUB/SRA; shift amount = rs2[4:0].
REQ-023 Arithmetic is 32-bit modulo 2^32 with no overflow detection; SLT/SLTI are signed, SLTU/SLTIU unsigned; the SLT family yields 0 or 1.
REQ-024 An unrecognised opcode or funct3/funct7 combination SHALL produce alu_out 0, wb_enable_out 0 and mem_we_out 0.
REQ-025 df_ex_enable = wb_enable_in && wb_reg_in != 0 && opcode != LOAD && !halted; df_ex_reg = wb_reg_in; df_ex_data = the combinational result.
REQ-026 Halt FSM has two states, RUN and HALT. RUN->HALT on an edge with ebreak_in=1. HALT is left only by reset.
REQ-027 In HALT, the registered outputs SHALL carry a NOP: iw_out 0x00000013, wb_enable_out 0, mem_we_out 0, alu_out 0, ebreak_out 1; pc_out holds its last value.
REQ-028 The EBREAK itself SHALL pass to MEM with ebreak_out=1, wb_enable_out=0 and mem_we_out=0.
REQ-029 ex_count SHALL increment by one per edge in RUN when iw_in != 0x00000013, wrapping 0xFFFFFFFF->0; it freezes in HALT and the EBREAK itself counts.

Reset
REQ-030 On reset: pc_out 0, iw_out 0x00000013, wb_reg_out 0, wb_enable_out 0, mem_we_out 0, alu_out 0, rs2_data_out 0, ebreak_out 0, ex_count 0, state RUN.
REQ-031 Reset asserted mid-HALT or mid-stream SHALL take priority over every other update on that edge.

Configuration
REQ-032 Macro RV32M_MUL_EN: when defined, OP with funct7=0000001 SHALL execute MUL/MULH/MULHSU/MULHU (funct3 000-011) single-cycle.
REQ-033 RV32M_MUL_EN: funct3 100-111 (divide/remainder) SHALL be treated as unrecognised per REQ-024.
REQ-034 Without RV32M_MUL_EN, every funct7=0000001 encoding SHALL be treated as unrecognised per REQ-024.

Structure
REQ-035 Package rv32i_pkg SHALL hold the opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM), NOP = 32'h00000013, EBREAK = 32'h00100073, and the ALU-op enum.
REQ-036 The result computation SHALL live in a combinational sub-module ex_alu; ex_stage holds the registers, FSM, counter and forwarding.

Verification
REQ-037 Run ADDI x5,x0,-1 (iw 0xFFF00293), then SLTIU with imm 1 on rs1=0xFFFFFFFF -> alu_out 0xFFFFFFFF, then 0; df_ex_enable=1 and df_ex_reg=5 during the ADDI cycle.
REQ-038 SRA with rs1=0x80000000, rs2=0x21 -> alu_out 0xC0000000; SRL -> 0x40000000.
REQ-039 LW with rs1=0x1000, imm 0x7FC -> alu_out 0x17FC and df_ex_enable=0; SW with S-imm -4 -> alu_out 0x0FFC, mem_we_out 1, rs2_data_out passed through.
REQ-040 EBREAK followed by ADDI x1,x0,5 -> ebreak_out 1 with wb_enable_out 0; next cycle iw_out 0x13, ex_count frozen, df_ex_enable 0; reset then returns to RUN with ex_count 0.
REQ-041 MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE with RV32M_MUL_EN defined; without the macro -> alu_out 0 and wb_enable_out 0.
REQ-042 ADDI to x0 with wb_enable_in=1 -> df_ex_enable 0; force ex_count to 0xFFFFFFFF and issue one non-NOP -> ex_count 0.
